combo_lock_param: RTL and testbench
===================================

# combo_lock_param

Parametrised N-button combination lock for the board-level lock designs. It replaces a two-button lock that ran on a derived divided clock. This block runs entirely on the system clock with an internal tick enable. It supports a configurable button count, code length, failed-attempt lockout, auto-relock and optional code reprogramming. It drives an unlock output, an alarm output and an active-low 7-segment status digit.

## Interface
- NBTN, 4: number of buttons, 2..16; digit width IDXW = max(1, $clog2(NBTN))
- CODE_LEN, 4: digits per code, 1..9
- DEFAULT_CODE, {2'd1,2'd3,2'd0,2'd2}: reset code, CODE_LEN*IDXW bits; digit i at [i*IDXW +: IDXW]; digit 0 is entered first
- TICK_DIV, 50000000: clk cycles per sample tick, ≥2
- MAX_FAIL, 3: consecutive failed codes before lockout, ≥1
- LOCKOUT_TICKS, 30: lockout duration in ticks
- OPEN_TICKS, 20: auto-relock timeout in ticks; 0 disables auto-relock
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn  in  NBTN  raw button levels, active-high
- prog  in  1  program-request level; ignored unless LOCK_PROGRAM_EN is defined
- unlock  out  1  high while OPEN or PROGRAM; reset 0
- alarm  out  1  high while LOCKOUT; reset 0
- state  out  3  state encoding; reset ENTRY (3'd0)
- seg  out  7  [1:7] = segments a..g, active-low; reset shows glyph "0" (7'b0000001)

## Operation
- Prescaler counts 0..TICK_DIV-1; tick is a 1-cycle pulse at TICK_DIV-1.
- btn and prog are registered only on tick.
- A press event is a 0→1 transition of any sampled button between consecutive ticks.
- On a tick with press events:
  - exactly one new button: valid digit = that button's index
  - two or more new buttons: invalid press
- States: ENTRY=0, OPEN=1, LOCKOUT=2, PROGRAM=3.
- ENTRY:
  - Each valid or invalid press increments cnt (0..CODE_LEN).
  - A mismatch flag is set if the digit ≠ code[cnt] or the press is invalid.
  - There is no early abort, so the position of an error is not revealed.
  - At cnt==CODE_LEN with no mismatch → OPEN, fail count cleared.
  - At cnt==CODE_LEN with a mismatch → fail count +1. If it reaches MAX_FAIL → LOCKOUT, else stay in ENTRY.
  - cnt and mismatch clear in both cases.
- OPEN:
  - Any press event → ENTRY (relock).
  - Auto-relock → ENTRY after OPEN_TICKS ticks without a press.
  - Timer restarts on entry to OPEN.
- LOCKOUT:
  - Buttons ignored; edge history is still updated, so a held button does not fire on exit.
  - After LOCKOUT_TICKS ticks → ENTRY; fail count and cnt cleared.
- seg digit:
  - ENTRY: cnt
  - OPEN: A
  - LOCKOUT: E
  - PROGRAM: b
  - Glyphs use the standard hex 7-segment map.
- Reset mid-operation restores all reset values. This includes the code register, which returns to DEFAULT_CODE even if it was reprogrammed.

## Timing
- State, cnt, counters and outputs update on the clk edge after the tick cycle. Latency is tick + 1 clk.
- A single press is detected on the first tick after the level rises. Bounce shorter than one tick period is filtered.
- When a relock press and the auto-relock timeout fall on the same tick, the press wins. The result is ENTRY either way; the press is not counted as a digit.
- The final-digit tick and the state change are processed in the same update. A failed final digit that hits MAX_FAIL goes directly to LOCKOUT.
- All outputs are registered; no combinational path runs from btn to any output.

## Configuration
- LOCK_PROGRAM_EN defined:
  - In OPEN, a 0→1 edge on sampled prog → PROGRAM; takes priority over a press on the same tick.
  - PROGRAM collects CODE_LEN valid digits into a shadow register.
  - After the last digit, the shadow commits atomically to the code register → OPEN.
  - An invalid press aborts: code is unchanged → OPEN.
  - No auto-relock applies in PROGRAM.
- LOCK_PROGRAM_EN undefined:
  - prog is unused and PROGRAM is unreachable.
  - The code is a constant DEFAULT_CODE.

## Structure
- Package lock_pkg holds:
  - state encoding localparams
  - hex-to-seg constant function (active-low)
  - display glyph codes for OPEN, LOCKOUT and PROGRAM
- Sub-module lock_btn_sampler contains the prescaler, tick generation, tick-rate sampling and edge detection. Its outputs are tick, press_valid, press_invalid and digit.

## Test plan
Common parameters: NBTN=4, CODE_LEN=4, code 2,0,3,1, TICK_DIV=4, MAX_FAIL=3, LOCKOUT_TICKS=8, OPEN_TICKS=16.
- Press 2,0,3,1 (one press per ≥2 ticks) → unlock=1, state=1, seg=A one clk after the 4th sampling tick.
- Press 2,0,3,0 → after the 4th press state=0 and cnt display returns to 0; unlock stays 0 throughout, with no earlier reaction at the wrong digit.
- Three wrong codes → alarm=1, state=2, seg=E; presses ignored. After 8 ticks → state=0, alarm=0, and the correct code then opens.
- Buttons 1 and 2 rising on the same tick as the first digit, then 0,3,1 → fails, fail count 1.
- OPEN with no press for 16 ticks → state=0, unlock=0. Separately, assert rst mid-entry at cnt=2 → immediately state=0, seg=0, unlock=0, alarm=0.
- With LOCK_PROGRAM_EN: open, raise prog, enter 3,3,1,0 → back to OPEN. Relock, then 3,3,1,0 opens and 2,0,3,1 fails. After rst, 2,0,3,1 opens again.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared encodings for the parametrised combination lock: state codes,
// status glyphs and the active-low hex-to-7-segment map (bit 6 = a ... bit 0 = g).
package lock_pkg;

  localparam logic [2:0] ST_ENTRY   = 3'd0;
  localparam logic [2:0] ST_OPEN    = 3'd1;
  localparam logic [2:0] ST_LOCKOUT = 3'd2;
  localparam logic [2:0] ST_PROGRAM = 3'd3;

  localparam logic [3:0] GLYPH_OPEN    = 4'hA;
  localparam logic [3:0] GLYPH_LOCKOUT = 4'hE;
  localparam logic [3:0] GLYPH_PROGRAM = 4'hB;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: hex2seg = 7'b0000001;
      4'h1: hex2seg = 7'b1001111;
      4'h2: hex2seg = 7'b0010010;
      4'h3: hex2seg = 7'b0000110;
      4'h4: hex2seg = 7'b1001100;
      4'h5: hex2seg = 7'b0100100;
      4'h6: hex2seg = 7'b0100000;
      4'h7: hex2seg = 7'b0001111;
      4'h8: hex2seg = 7'b0000000;
      4'h9: hex2seg = 7'b0000100;
      4'hA: hex2seg = 7'b0001000;
      4'hB: hex2seg = 7'b1100000;
      4'hC: hex2seg = 7'b0110001;
      4'hD: hex2seg = 7'b1000010;
      4'hE: hex2seg = 7'b0110000;
      default: hex2seg = 7'b0111000;
    endcase
  endfunction

endpackage

// File: rtl/lock_btn_sampler.sv
// Prescaler, tick-rate button sampling and rising-edge press classification.
// Sampling only on tick filters bounce shorter than one tick period.
module lock_btn_sampler #(
  parameter int NBTN     = 4,
  parameter int TICK_DIV = 4,
  parameter int IDXW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] i_btn,
  output logic            o_tick,
  output logic            o_press_valid,
  output logic            o_press_invalid,
  output logic [IDXW-1:0] o_digit
);

  localparam int DW = $clog2(TICK_DIV);

  logic [DW-1:0]   r_div;
  logic [NBTN-1:0] r_smp;
  logic [NBTN-1:0] w_new;
  logic [4:0]      w_nset;

  assign o_tick = (r_div == DW'(TICK_DIV - 1));
  assign w_new  = i_btn & ~r_smp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_smp <= '0;
    end else begin
      if (o_tick) begin
        r_div <= '0;
        r_smp <= i_btn;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  always_comb begin
    w_nset  = '0;
    o_digit = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (w_new[i]) begin
        w_nset  = w_nset + 5'd1;
        o_digit = IDXW'(i);
      end
    end
    o_press_valid   = o_tick && (w_nset == 5'd1);
    o_press_invalid = o_tick && (w_nset > 5'd1);
  end

endmodule

// File: rtl/combo_lock_param.sv
// N-button combination lock with lockout, auto-relock and registered status outputs.
// Optional code reprogramming is enabled by defining LOCK_PROGRAM_EN.
module combo_lock_param
  import lock_pkg::*;
#(
  parameter int NBTN          = 4,
  parameter int CODE_LEN      = 4,
  parameter logic [CODE_LEN*$clog2(NBTN)-1:0] DEFAULT_CODE = {2'd1, 2'd3, 2'd0, 2'd2},
  parameter int TICK_DIV      = 50000000,
  parameter int MAX_FAIL      = 3,
  parameter int LOCKOUT_TICKS = 30,
  parameter int OPEN_TICKS    = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn,
  input  logic            prog,
  output logic            unlock,
  output logic            alarm,
  output logic [2:0]      state,
  output logic [6:0]      seg
);

  localparam int IDXW    = $clog2(NBTN);
  localparam int CW      = $clog2(CODE_LEN + 1);
  localparam int FW      = $clog2(MAX_FAIL + 1);
  localparam int TMAX    = (OPEN_TICKS > LOCKOUT_TICKS) ? OPEN_TICKS :
                           ((LOCKOUT_TICKS > 0) ? LOCKOUT_TICKS : 1);
  localparam int TW      = $clog2(TMAX + 1);
  localparam int LK_LAST = (LOCKOUT_TICKS > 0) ? LOCKOUT_TICKS - 1 : 0;
  localparam int OP_LAST = (OPEN_TICKS > 0) ? OPEN_TICKS - 1 : 0;

  logic                     w_tick, w_valid, w_invalid, w_press, w_bad;
  logic [IDXW-1:0]          w_digit, w_code_cur;
  logic [CODE_LEN*IDXW-1:0] w_code;

  logic [2:0]    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_mis, w_mis_nxt;
  logic [FW-1:0] r_fail, w_fail_nxt, w_fail_inc;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic          r_unlock, r_alarm, w_unlock_nxt, w_alarm_nxt;
  logic [6:0]    r_seg, w_seg_nxt;

  lock_btn_sampler #(
    .NBTN     (NBTN),
    .TICK_DIV (TICK_DIV),
    .IDXW     (IDXW)
  ) u_sampler (
    .clk             (clk),
    .rst             (rst),
    .i_btn           (btn),
    .o_tick          (w_tick),
    .o_press_valid   (w_valid),
    .o_press_invalid (w_invalid),
    .o_digit         (w_digit)
  );

`ifdef LOCK_PROGRAM_EN
  logic                     r_prog, w_prog_rise;
  logic [CODE_LEN*IDXW-1:0] r_code, w_code_nxt;
  logic [CODE_LEN*IDXW-1:0] r_shadow, w_shadow_nxt;

  assign w_code      = r_code;
  assign w_prog_rise = w_tick && prog && !r_prog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prog   <= 1'b0;
      r_code   <= DEFAULT_CODE;
      r_shadow <= '0;
    end else begin
      if (w_tick) r_prog <= prog;
      r_code   <= w_code_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end
`else
  logic w_unused_prog;
  assign w_unused_prog = prog;
  assign w_code        = DEFAULT_CODE;
`endif

  assign w_code_cur = w_code[int'(r_cnt)*IDXW +: IDXW];
  assign w_press    = w_valid || w_invalid;
  assign w_bad      = w_invalid || (w_digit != w_code_cur);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_fail_inc = r_fail + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_ENTRY;
      r_cnt    <= '0;
      r_mis    <= 1'b0;
      r_fail   <= '0;
      r_timer  <= '0;
      r_unlock <= 1'b0;
      r_alarm  <= 1'b0;
      r_seg    <= hex2seg(4'h0);
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_mis    <= w_mis_nxt;
      r_fail   <= w_fail_nxt;
      r_timer  <= w_timer_nxt;
      r_unlock <= w_unlock_nxt;
      r_alarm  <= w_alarm_nxt;
      r_seg    <= w_seg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mis_nxt   = r_mis;
    w_fail_nxt  = r_fail;
    w_timer_nxt = r_timer;
`ifdef LOCK_PROGRAM_EN
    w_code_nxt   = r_code;
    w_shadow_nxt = r_shadow;
`endif
    case (r_state)
      ST_ENTRY: begin
        // The whole code is always collected so an error position is never revealed.
        if (w_press) begin
          if (w_cnt_inc == CW'(CODE_LEN)) begin
            w_cnt_nxt = '0;
            w_mis_nxt = 1'b0;
            if (!(r_mis || w_bad)) begin
              w_state_nxt = ST_OPEN;
              w_fail_nxt  = '0;
              w_timer_nxt = '0;
            end else begin
              w_fail_nxt = w_fail_inc;
              if (w_fail_inc == FW'(MAX_FAIL)) begin
                w_state_nxt = ST_LOCKOUT;
                w_timer_nxt = '0;
              end
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
            w_mis_nxt = r_mis || w_bad;
          end
        end
      end
      ST_OPEN: begin
`ifdef LOCK_PROGRAM_EN
        if (w_prog_rise) begin
          w_state_nxt = ST_PROGRAM;
          w_cnt_nxt   = '0;
        end else
`endif
        if (w_press) begin
          w_state_nxt = ST_ENTRY;
        end else if (w_tick && (OPEN_TICKS != 0)) begin
          if (r_timer == TW'(OP_LAST)) w_state_nxt = ST_ENTRY;
          else                         w_timer_nxt = r_timer + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (w_tick) begin
          if (r_timer == TW'(LK_LAST)) begin
            w_state_nxt = ST_ENTRY;
            w_fail_nxt  = '0;
            w_cnt_nxt   = '0;
            w_mis_nxt   = 1'b0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end
`ifdef LOCK_PROGRAM_EN
      ST_PROGRAM: begin
        if (w_invalid) begin
          w_state_nxt = ST_OPEN;
          w_cnt_nxt   = '0;
          w_timer_nxt = '0;
        end else if (w_valid) begin
          w_shadow_nxt[int'(r_cnt)*IDXW +: IDXW] = w_digit;
          if (w_cnt_inc == CW'(CODE_LEN)) begin
            w_code_nxt  = w_shadow_nxt;
            w_state_nxt = ST_OPEN;
            w_cnt_nxt   = '0;
            w_timer_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
`endif
      default: w_state_nxt = ST_ENTRY;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    w_unlock_nxt = (w_state_nxt == ST_OPEN) || (w_state_nxt == ST_PROGRAM);
    w_alarm_nxt  = (w_state_nxt == ST_LOCKOUT);
    case (w_state_nxt)
      ST_OPEN:    w_seg_nxt = hex2seg(GLYPH_OPEN);
      ST_LOCKOUT: w_seg_nxt = hex2seg(GLYPH_LOCKOUT);
      ST_PROGRAM: w_seg_nxt = hex2seg(GLYPH_PROGRAM);
      default:    w_seg_nxt = hex2seg(4'(w_cnt_nxt));
    endcase
  end

  assign unlock = r_unlock;
  assign alarm  = r_alarm;
  assign state  = r_state;
  assign seg    = r_seg;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param: code 2,0,3,1 on 4 buttons, 4-cycle tick.
// Programming scenario is compiled in only when LOCK_PROGRAM_EN is defined.
module tb_combo_lock_param;

  localparam logic [6:0] SEG0  = 7'b0000001;
  localparam logic [6:0] SEG1  = 7'b1001111;
  localparam logic [6:0] SEG2  = 7'b0010010;
  localparam logic [6:0] SEG3  = 7'b0000110;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_B = 7'b1100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       prog = 1'b0;
  logic       unlock, alarm;
  logic [2:0] state;
  logic [6:0] seg;
  int         n_tests = 0;
  int         n_fail  = 0;

  combo_lock_param #(
    .NBTN          (4),
    .CODE_LEN      (4),
    .DEFAULT_CODE  ({2'd1, 2'd3, 2'd0, 2'd2}),
    .TICK_DIV      (4),
    .MAX_FAIL      (3),
    .LOCKOUT_TICKS (8),
    .OPEN_TICKS    (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .prog   (prog),
    .unlock (unlock),
    .alarm  (alarm),
    .state  (state),
    .seg    (seg)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn = '0; prog = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Held for exactly two ticks and released for two, so exactly 3 ticks
  // elapse after the detecting tick by the time this returns.
  task automatic press_mask(input logic [3:0] m);
    @(negedge clk);
    btn = m;
    repeat (8) @(negedge clk);
    btn = '0;
    repeat (7) @(negedge clk);
  endtask

  task automatic press(input int b);
    logic [3:0] m;
    m = 4'b0001 << b;
    press_mask(m);
  endtask

  task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
    press(d0); press(d1); press(d2); press(d3);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_tests++;
    if (seg !== SEG0) begin n_fail++; $display("FAIL reset_seg: got %b want %b", seg, SEG0); end
    n_tests++;
    if (unlock !== 1'b0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: unlock=%b alarm=%b want 0 0", unlock, alarm);
    end
    n_tests++;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    if (state !== 3'd0 || seg !== SEG0) begin
      n_fail++; $display("FAIL idle_after_reset: state=%0d seg=%b want 0 %b", state, seg, SEG0);
    end
    n_tests++;
  endtask

  task automatic test_open();
    int n;
    do_reset();
    press(2);
    if (seg !== SEG1) begin n_fail++; $display("FAIL open_cnt1: seg=%b want %b", seg, SEG1); end
    n_tests++;
    press(0);
    if (seg !== SEG2) begin n_fail++; $display("FAIL open_cnt2: seg=%b want %b", seg, SEG2); end
    n_tests++;
    press(3);
    if (seg !== SEG3 || unlock !== 1'b0) begin
      n_fail++; $display("FAIL open_cnt3: seg=%b unlock=%b want %b 0", seg, unlock, SEG3);
    end
    n_tests++;
    @(negedge clk);
    btn = 4'b0010;
    n = 0;
    while (unlock !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (n < 1 || n > 4) begin n_fail++; $display("FAIL open_latency: got %0d clk want 1..4", n); end
    n_tests++;
    repeat (8 - n) @(negedge clk);
    btn = '0;
    repeat (8) @(negedge clk);
    if (state !== 3'd1 || seg !== SEG_A || unlock !== 1'b1) begin
      n_fail++; $display("FAIL open_state: state=%0d seg=%b unlock=%b want 1 %b 1", state, seg, unlock, SEG_A);
    end
    n_tests++;
  endtask

  task automatic test_wrong_last();
    do_reset();
    press(2); press(0); press(3);
    if (unlock !== 1'b0 || seg !== SEG3) begin
      n_fail++; $display("FAIL wrong_pre: unlock=%b seg=%b want 0 %b", unlock, seg, SEG3);
    end
    n_tests++;
    press(0);
    if (state !== 3'd0 || seg !== SEG0 || unlock !== 1'b0) begin
      n_fail++; $display("FAIL wrong_last: state=%0d seg=%b unlock=%b want 0 %b 0", state, seg, unlock, SEG0);
    end
    n_tests++;
  endtask

  task automatic test_lockout();
    do_reset();
    press(0);
    if (seg !== SEG1) begin n_fail++; $display("FAIL no_early_abort: seg=%b want %b", seg, SEG1); end
    n_tests++;
    press(0); press(3); press(1);
    enter_code(1, 1, 1, 1);
    if (state !== 3'd0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL two_fails: state=%0d alarm=%b want 0 0", state, alarm);
    end
    n_tests++;
    enter_code(3, 3, 3, 3);
    if (state !== 3'd2 || alarm !== 1'b1 || seg !== SEG_E || unlock !== 1'b0) begin
      n_fail++; $display("FAIL lockout_enter: state=%0d alarm=%b seg=%b unlock=%b want 2 1 %b 0",
                         state, alarm, seg, unlock, SEG_E);
    end
    n_tests++;
    @(negedge clk);
    btn = 4'b0100;
    repeat (3) @(negedge clk);
    btn = '0;
    if (state !== 3'd2 || seg !== SEG_E) begin
      n_fail++; $display("FAIL lockout_ignore: state=%0d seg=%b want 2 %b", state, seg, SEG_E);
    end
    n_tests++;
    repeat (12) @(negedge clk);
    if (state !== 3'd2) begin n_fail++; $display("FAIL lockout_tick7: state=%0d want 2", state); end
    n_tests++;
    repeat (4) @(negedge clk);
    if (state !== 3'd0 || alarm !== 1'b0 || seg !== SEG0) begin
      n_fail++; $display("FAIL lockout_exit: state=%0d alarm=%b seg=%b want 0 0 %b", state, alarm, seg, SEG0);
    end
    n_tests++;
    enter_code(2, 0, 3, 1);
    if (state !== 3'd1) begin n_fail++; $display("FAIL open_after_lockout: state=%0d want 1", state); end
    n_tests++;
  endtask

  task automatic test_invalid();
    do_reset();
    press_mask(4'b0110);
    if (seg !== SEG1) begin n_fail++; $display("FAIL invalid_counts: seg=%b want %b", seg, SEG1); end
    n_tests++;
    press(0); press(3); press(1);
    if (state !== 3'd0 || unlock !== 1'b0) begin
      n_fail++; $display("FAIL invalid_fails: state=%0d unlock=%b want 0 0", state, unlock);
    end
    n_tests++;
    enter_code(0, 0, 0, 0);
    if (state !== 3'd0) begin n_fail++; $display("FAIL invalid_fail2: state=%0d want 0", state); end
    n_tests++;
    enter_code(0, 0, 0, 0);
    if (state !== 3'd2) begin n_fail++; $display("FAIL invalid_fail3: state=%0d want 2", state); end
    n_tests++;
  endtask

  task automatic test_autorelock();
    do_reset();
    enter_code(2, 0, 3, 1);
    repeat (48) @(negedge clk);
    if (state !== 3'd1 || unlock !== 1'b1) begin
      n_fail++; $display("FAIL relock_tick15: state=%0d unlock=%b want 1 1", state, unlock);
    end
    n_tests++;
    repeat (4) @(negedge clk);
    if (state !== 3'd0 || unlock !== 1'b0 || seg !== SEG0) begin
      n_fail++; $display("FAIL relock_tick16: state=%0d unlock=%b seg=%b want 0 0 %b", state, unlock, seg, SEG0);
    end
    n_tests++;
    enter_code(2, 0, 3, 1);
    press(1);
    if (state !== 3'd0 || seg !== SEG0) begin
      n_fail++; $display("FAIL relock_press: state=%0d seg=%b want 0 %b", state, seg, SEG0);
    end
    n_tests++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(2); press(0);
    if (seg !== SEG2) begin n_fail++; $display("FAIL mid_cnt2: seg=%b want %b", seg, SEG2); end
    n_tests++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (state !== 3'd0 || seg !== SEG0 || unlock !== 1'b0 || alarm !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: state=%0d seg=%b unlock=%b alarm=%b want 0 %b 0 0",
                         state, seg, unlock, alarm, SEG0);
    end
    n_tests++;
    @(negedge clk);
    rst = 1'b0;
    enter_code(2, 0, 3, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (unlock !== 1'b0 || state !== 3'd0) begin
      n_fail++; $display("FAIL open_reset: unlock=%b state=%0d want 0 0", unlock, state);
    end
    n_tests++;
    @(negedge clk);
    rst = 1'b0;
  endtask

`ifdef LOCK_PROGRAM_EN
  task automatic test_program();
    do_reset();
    enter_code(2, 0, 3, 1);
    @(negedge clk);
    prog = 1'b1;
    repeat (8) @(negedge clk);
    prog = 1'b0;
    if (state !== 3'd3 || seg !== SEG_B || unlock !== 1'b1) begin
      n_fail++; $display("FAIL prog_enter: state=%0d seg=%b unlock=%b want 3 %b 1", state, seg, unlock, SEG_B);
    end
    n_tests++;
    enter_code(3, 3, 1, 0);
    if (state !== 3'd1) begin n_fail++; $display("FAIL prog_commit: state=%0d want 1", state); end
    n_tests++;
    press(2);
    enter_code(3, 3, 1, 0);
    if (state !== 3'd1) begin n_fail++; $display("FAIL prog_new_opens: state=%0d want 1", state); end
    n_tests++;
    press(2);
    enter_code(2, 0, 3, 1);
    if (state !== 3'd0) begin n_fail++; $display("FAIL prog_old_fails: state=%0d want 0", state); end
    n_tests++;
    do_reset();
    enter_code(2, 0, 3, 1);
    if (state !== 3'd1) begin n_fail++; $display("FAIL prog_reset_default: state=%0d want 1", state); end
    n_tests++;
  endtask
`endif

  initial begin
    test_reset();
    test_open();
    test_wrong_last();
    test_lockout();
    test_invalid();
    test_autorelock();
    test_reset_mid();
`ifdef LOCK_PROGRAM_EN
    test_program();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
